// File: rtl/subtr_unit.sv
// -----------------------------------------------------------------------------
// subtr_unit
//   Registered adder/subtractor built on a ripple-carry full-adder chain.
//   mod = 0 : s = a + b + cin
//   mod = 1 : s = a - b - cin   (cin acts as borrow-in)
//   Result and status flags are registered with one cycle of latency.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears every output register)
//   in_valid   operands valid this cycle, captured on the rising clk edge
//   a, b       operands (a = minuend, b = subtrahend when subtracting)
//   cin        carry-in (add) / borrow-in (subtract)
//   mod        0 = add, 1 = subtract
//   s          registered result (modulo 2^WIDTH)
//   cout       raw carry-out of the MSB stage (1 = no borrow when subtracting)
//   ovf        signed two's-complement overflow
//   zero       registered result equals zero
//   out_valid  s/cout/ovf/zero hold a fresh result
//
// Handshake: in_valid is a plain strobe with no back-pressure. Every rising
// edge with in_valid=1 captures one operation, and out_valid is high for
// exactly the cycle following each capture. With in_valid=0 the data outputs
// hold their last values and out_valid drops, so operand values while
// in_valid=0 never reach the outputs.
// -----------------------------------------------------------------------------
module subtr_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mod,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    // Subtraction is a + ~b + 1 - cin. Inverting b and folding the "+1" and
    // the borrow into a single chain carry-in (cin ^ mod) lets one adder
    // chain serve both modes.
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH:0]   c;

    assign bi   = b ^ {WIDTH{mod}};
    assign c[0] = cin ^ mod;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_c[i] = a[i] ^ bi[i] ^ c[i];
        assign c[i+1]   = (a[i] & bi[i]) | (c[i] & (a[i] ^ bi[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum_c;
                cout <= c[WIDTH];
                // Signed overflow: carry into the sign bit differs from
                // carry out of it.
                ovf  <= c[WIDTH] ^ c[WIDTH-1];
                // zero is a register of its own (not derived from s) so that
                // reset can hold it low while s is also zero.
                zero <= (sum_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_subtr_unit.sv
module tb_subtr_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         mod;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {s, cout, ovf, zero}.
    logic [W+2:0] exp_q[$];

    subtr_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mod       (mod),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got still running, want finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Works on whole integers: the true sum/difference, then reduce modulo
    // 2^W, take carry/no-borrow from the unsigned range and overflow from the
    // signed range.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic mmod);
        int ua, ub, sa, sb, total, sres;
        logic [W-1:0] r;
        logic         co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!mmod) begin
            total = ua + ub + int'(mcin);
            sres  = sa + sb + int'(mcin);
            co    = (total >= (1 << W));
        end else begin
            total = ua - ub - int'(mcin);
            sres  = sa - sb - int'(mcin);
            co    = (ua >= ub + int'(mcin));
        end
        r  = W'(total);
        ov = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
        return {r, co, ov, (r == '0)};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tmod);
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tcin;
        mod      = tmod;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        cin      = 1'bx;
        mod      = 1'bx;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; mod = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", {s, cout, ovf, zero, out_valid}, 12'h000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sub_gt;
        drive_op(8'hB9, 8'h8F, 1'b0, 1'b1);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h2A, 4'b1001}) begin
            errors++;
            $display("FAIL sub_gt_b9_8f: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h2A, 4'b1001});
        end
        drive_op(8'hD5, 8'hD4, 1'b0, 1'b1);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h01, 4'b1001}) begin
            errors++;
            $display("FAIL sub_gt_d5_d4: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h01, 4'b1001});
        end
    endtask

    task automatic test_sub_lt;
        drive_op(8'hB9, 8'hE5, 1'b0, 1'b1);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'hD4, 4'b0001}) begin
            errors++;
            $display("FAIL sub_lt_b9_e5: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'hD4, 4'b0001});
        end
        drive_op(8'hB7, 8'hC0, 1'b0, 1'b1);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'hF7, 4'b0001}) begin
            errors++;
            $display("FAIL sub_lt_b7_c0: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'hF7, 4'b0001});
        end
    endtask

    task automatic test_back_to_back_equal;
        logic [W-1:0] vals[4];
        vals = '{8'h9A, 8'h97, 8'h2E, 8'hCC};
        // Consecutive drive_op calls keep in_valid high on every edge.
        for (int i = 0; i < 4; i++) begin
            drive_op(vals[i], vals[i], 1'b0, 1'b1);
            checks++;
            if ({s, cout, ovf, zero, out_valid} !== {8'h00, 4'b1011}) begin
                errors++;
                $display("FAIL sub_eq_b2b[%0d] operand %h: got %h want %h", i, vals[i],
                         {s, cout, ovf, zero, out_valid}, {8'h00, 4'b1011});
            end
        end
    endtask

    task automatic test_add;
        drive_op(8'hE6, 8'h1A, 1'b0, 1'b0);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h00, 4'b1011}) begin
            errors++;
            $display("FAIL add_carry_e6_1a: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h00, 4'b1011});
        end
        drive_op(8'h7F, 8'h01, 1'b0, 1'b0);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h80, 4'b0101}) begin
            errors++;
            $display("FAIL add_ovf_7f_01: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h80, 4'b0101});
        end
        drive_op(8'h10, 8'h20, 1'b1, 1'b0);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h31, 4'b0001}) begin
            errors++;
            $display("FAIL add_cin_10_20: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h31, 4'b0001});
        end
    endtask

    task automatic test_borrow_in;
        // 0x9C - 0x43 - 1 = 0x58; as signed -100 - 67 - 1 = -168 overflows.
        drive_op(8'h9C, 8'h43, 1'b1, 1'b1);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h58, 4'b1101}) begin
            errors++;
            $display("FAIL borrow_in_9c_43: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h58, 4'b1101});
        end
    endtask

    task automatic test_idle_hold;
        // Operands are X while idle; outputs must keep the last result.
        drive_idle();
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h58, 4'b1100}) begin
            errors++;
            $display("FAIL idle_hold_1: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h58, 4'b1100});
        end
        drive_idle();
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h58, 4'b1100}) begin
            errors++;
            $display("FAIL idle_hold_2: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h58, 4'b1100});
        end
    endtask

    task automatic test_async_reset;
        drive_op(8'hB9, 8'h8F, 1'b0, 1'b1);
        checks++;
        if ({s, out_valid} !== {8'h2A, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_result: got %h want %h", {s, out_valid}, {8'h2A, 1'b1});
        end
        // Assert reset between edges and keep a capture pending across an edge.
        #2;
        in_valid = 1'b1;
        a = 8'h55; b = 8'h11; cin = 1'b0; mod = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h want %h", {s, cout, ovf, zero, out_valid}, 12'h000);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_discards_capture: got %h want %h", {s, cout, ovf, zero, out_valid}, 12'h000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({s, out_valid} !== {8'h00, 1'b0}) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got %h want %h", i, {s, out_valid}, 9'h000);
            end
        end
        // First valid operation after reset produces a result.
        drive_op(8'h05, 8'h03, 1'b0, 1'b0);
        checks++;
        if ({s, cout, ovf, zero, out_valid} !== {8'h08, 4'b0001}) begin
            errors++;
            $display("FAIL first_after_reset: got %h want %h", {s, cout, ovf, zero, out_valid}, {8'h08, 4'b0001});
        end
    endtask

    task automatic test_random;
        logic [W+2:0] last;
        logic [W+2:0] exp;
        logic [W-1:0] ra, rb;
        logic         rc, rm;
        bit           valid;
        last = '0;
        for (int i = 0; i < 300; i++) begin
            valid = (i == 0) || ($urandom_range(0, 4) != 0);
            if (valid) begin
                ra = W'($urandom_range(0, 255));
                rb = W'($urandom_range(0, 255));
                // Bias toward equal operands and the extreme values.
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: ra = 8'h80;
                    2: rb = 8'h7F;
                    default: ;
                endcase
                rc = 1'($urandom_range(0, 1));
                rm = 1'($urandom_range(0, 1));
                exp_q.push_back(model(ra, rb, rc, rm));
                drive_op(ra, rb, rc, rm);
                exp  = exp_q.pop_front();
                last = exp;
                checks++;
                if ({s, cout, ovf, zero, out_valid} !== {exp, 1'b1}) begin
                    errors++;
                    $display("FAIL random[%0d] a=%h b=%h cin=%b mod=%b: got %h want %h", i, ra, rb, rc, rm,
                             {s, cout, ovf, zero, out_valid}, {exp, 1'b1});
                end
            end else begin
                drive_idle();
                checks++;
                if ({s, cout, ovf, zero, out_valid} !== {last, 1'b0}) begin
                    errors++;
                    $display("FAIL random_idle[%0d]: got %h want %h", i,
                             {s, cout, ovf, zero, out_valid}, {last, 1'b0});
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sub_gt();
        test_sub_lt();
        test_back_to_back_equal();
        test_add();
        test_borrow_in();
        test_idle_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/subtr_unit.md
Name: subtr_unit

Overview:
- 8-bit registered adder/subtractor built on a ripple-carry full-adder chain.
- `mod` selects add (0) or two's-complement subtract (1); `cin` is carry-in when adding and borrow-in when subtracting.
- Result and status flags are registered with one clock of latency, with a valid strobe.
- Used as the arithmetic datapath element in the lab ALU path.

Parameters:
- WIDTH, 8, operand and result width in bits. All behaviour below holds for any WIDTH ≥ 2; the tests use 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle; capture on rising `clk` edge
- a  input  WIDTH  operand A (minuend when subtracting)
- b  input  WIDTH  operand B (subtrahend when subtracting)
- cin  input  1  carry-in (add) / borrow-in (subtract)
- mod  input  1  0 = add, 1 = subtract
- s  output  WIDTH  result
- cout  output  1  carry-out of the MSB stage
- ovf  output  1  signed (two's-complement) overflow
- zero  output  1  1 when `s` == 0
- out_valid  output  1  `s`/`cout`/`ovf`/`zero` hold a fresh result

Behaviour:
- Operand conditioning:
  - bi = b XOR {WIDTH{mod}}.
  - Chain carry-in c0 = cin XOR mod.
- Arithmetic:
  - Add (mod=0): s = a + b + cin.
  - Subtract (mod=1): s = a + ~b + 1 − cin = a − b − cin.
- Structure: WIDTH chained full adders (sum = x^y^c, carry = xy | c(x^y)). A behavioural `+` is acceptable if results are bit-identical.
- cout = c_WIDTH, the raw adder carry, with no inversion in subtract mode.
  - Subtract with cin=0: cout=1 iff a ≥ b unsigned (no borrow); cout=0 iff a < b.
- ovf = c_WIDTH XOR c_(WIDTH−1).
- zero = (s == 0), computed from the same registered result.
- Timing:
  - On each rising `clk` with in_valid=1, the combinational result is registered into `s`/`cout`/`ovf`/`zero`, and out_valid is set to 1 on that same edge.
  - On a rising edge with in_valid=0, out_valid goes to 0 and all data outputs hold their previous values.
  - Latency: exactly 1 cycle. Throughput: 1 operation per cycle, back-to-back with no bubbles.
- Reset:
  - rst_n low immediately forces s=0, cout=0, ovf=0, zero=0, out_valid=0, independent of `clk`.
  - Reset asserted mid-operation discards the pending capture.
  - After rst_n deasserts, the first rising edge with in_valid=1 produces a valid result.
- Wrap-around: results are modulo 2^WIDTH. No saturation. The carry/borrow is reported only via `cout`.
- Equal operands, subtract, cin=0: s=0, zero=1, cout=1, ovf=0.
- No internal state other than the output registers. X/Z on inputs while in_valid=0 must not affect outputs.

Test Plan:
- Subtract with A>B: mod=1, cin=0, in_valid=1.
  - a=0xB9, b=0x8F → next cycle s=0x2A, cout=1, ovf=0, zero=0, out_valid=1.
  - a=0xD5, b=0xD4 → s=0x01, cout=1.
- Subtract with A<B: mod=1, cin=0.
  - a=0xB9, b=0xE5 → s=0xD4, cout=0, ovf=0.
  - a=0xB7, b=0xC0 → s=0xF7, cout=0.
- Subtract with A=B: mod=1, cin=0.
  - a=0x9A, b=0x9A → s=0x00, zero=1, cout=1.
  - Repeat with 0x97, 0x2E, 0xCC, applied back-to-back on consecutive cycles → every cycle zero=1, out_valid=1.
- Add and carry:
  - mod=0, cin=0, a=0xE6, b=0x1A → s=0x00, cout=1, zero=1.
  - mod=0, a=0x7F, b=0x01 → s=0x80, ovf=1, cout=0.
- Borrow-in: mod=1, cin=1, a=0x9C, b=0x43 → s=0x58, cout=1.
- Reset and valid:
  - Assert rst_n=0 asynchronously between clock edges after a valid result → all outputs 0 immediately.
  - Release rst_n, drive in_valid=0 for 2 cycles → out_valid stays 0 and s stays 0.
